// File: rtl/key_gated_deserializer_if.sv
// Output word stream of key_gated_deserializer: FIFO head data/mode with valid/ready handshake.
// The master modport drives the stream; the slave modport is the command consumer.
interface key_gated_deserializer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] outData;
  logic              outMode;
  logic              outValid;
  logic              outReady;

  modport master (output outData, output outMode, output outValid, input  outReady);
  modport slave  (input  outData, input  outMode, input  outValid, output outReady);
endinterface

// File: rtl/key_gated_deserializer.sv
// Serial-to-parallel word assembler gated by the key-detection unlock flag, with optional
// XOR scrambling and an output FIFO. Define PARITY_CHECK_EN to require an even-parity bit per word.
module key_gated_deserializer #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] KEY        = DATA_W'(8'hA5)
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mode,
  input  logic bitIn,
  input  logic bitValid,
  key_gated_deserializer_if.master out_if,
  output logic overflow,
  output logic busy
`ifdef PARITY_CHECK_EN
  ,
  output logic parityErr
`endif
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_e;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              mode;
  } entry_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              word_mode_q, word_mode_d;
  logic              overflow_q, overflow_d;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  entry_t            fifo_mem [FIFO_DEPTH];

  logic              push;
  entry_t            push_entry;
  logic              do_pop;
  logic              fifo_full;
  logic              fifo_write;
  logic [DATA_W-1:0] shift_in;
  logic              cur_mode;

`ifdef PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
`endif

  assign shift_in = {shreg_q[DATA_W-2:0], bitIn};
  // The first bit of a word samples mode directly; later bits reuse the latched value.
  assign cur_mode = (bit_cnt_q == '0) ? mode : word_mode_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    word_mode_d  = word_mode_q;
    push         = 1'b0;
    push_entry   = '0;
`ifdef PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (active) state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (!active) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else if (bitValid) begin
          shreg_d     = shift_in;
          word_mode_d = cur_mode;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
            // Count parks at DATA_W so busy stays high while the parity bit is awaited.
            bit_cnt_d = CNT_W'(DATA_W);
            state_d   = S_PARITY;
`else
            push            = 1'b1;
            push_entry.data = shift_in ^ (cur_mode ? KEY : '0);
            push_entry.mode = cur_mode;
            bit_cnt_d       = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (!active) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else if (bitValid) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          // Even parity over the raw bits: data ones plus the parity bit must be even.
          if (^{shreg_q, bitIn} == 1'b0) begin
            push            = 1'b1;
            push_entry.data = shreg_q ^ (word_mode_q ? KEY : '0);
            push_entry.mode = word_mode_q;
          end else begin
            parity_err_d = 1'b1;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push when the consumer drains simultaneously.
  always_comb begin
    do_pop     = (count_q != '0) && out_if.outReady;
    fifo_full  = (count_q == FCNT_W'(FIFO_DEPTH));
    fifo_write = push && (!fifo_full || do_pop);
    overflow_d = push && fifo_full && !do_pop;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (fifo_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    unique case ({fifo_write, do_pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      word_mode_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      word_mode_q  <= word_mode_d;
      overflow_q   <= overflow_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // NOTE: storage is left unreset; outputs are masked by the reset count instead.
  always_ff @(posedge clk) begin
    if (fifo_write) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign out_if.outValid = (count_q != '0);
  assign out_if.outData  = out_if.outValid ? fifo_mem[rd_ptr_q].data : '0;
  assign out_if.outMode  = out_if.outValid ? fifo_mem[rd_ptr_q].mode : 1'b0;
  // Drop reports are registered so they line up with the cycle the word would have appeared.
  assign overflow        = overflow_q;
  assign busy            = (bit_cnt_q != '0);
`ifdef PARITY_CHECK_EN
  assign parityErr       = parity_err_q;
`endif

endmodule

// File: tb/tb_key_gated_deserializer.sv
// Self-checking bench for key_gated_deserializer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model. Honors PARITY_CHECK_EN.
module tb_key_gated_deserializer;
  localparam int        DATA_W     = 8;
  localparam int        FIFO_DEPTH = 4;
  localparam logic [7:0] KEY       = 8'hA5;

  logic clk = 1'b0;
  logic reset, active, mode, bitIn, bitValid;
  logic overflow, busy;
`ifdef PARITY_CHECK_EN
  logic parityErr;
`endif

  key_gated_deserializer_if #(.DATA_W(DATA_W)) out_if ();

  key_gated_deserializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .KEY(KEY)) dut (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .mode     (mode),
    .bitIn    (bitIn),
    .bitValid (bitValid),
    .out_if   (out_if.master),
    .overflow (overflow),
    .busy     (busy)
`ifdef PARITY_CHECK_EN
    ,
    .parityErr(parityErr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words are kept as (data << 1) | mode in a queue.
  bit m_shift, m_wmode, m_par_pend, m_ovf, m_perr;
  int m_cnt, m_acc;
  int q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shift = 0; m_wmode = 0; m_par_pend = 0; m_ovf = 0; m_perr = 0;
    m_cnt = 0; m_acc = 0;
    q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit pop, full, have_word;
    pop       = (q.size() != 0) && out_if.outReady;
    full      = (q.size() == FIFO_DEPTH);
    have_word = 0;
    m_ovf     = 0;
    m_perr    = 0;
    if (!m_shift) begin
      m_shift = active;
    end else if (!active) begin
      m_shift = 0; m_cnt = 0; m_par_pend = 0;
    end else if (bitValid) begin
      if (m_par_pend) begin
        m_par_pend = 0;
        m_cnt      = 0;
        if ((($countones(m_acc) + int'(bitIn)) % 2) == 0) have_word = 1;
        else m_perr = 1;
      end else begin
        if (m_cnt == 0) m_wmode = mode;
        m_acc = ((m_acc << 1) | int'(bitIn)) & 'hFF;
        m_cnt++;
        if (m_cnt == DATA_W) begin
`ifdef PARITY_CHECK_EN
          m_par_pend = 1;
`else
          have_word = 1;
          m_cnt     = 0;
`endif
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (have_word) begin
      if (full && !pop) m_ovf = 1;
      else q.push_back(((m_acc ^ (m_wmode ? int'(KEY) : 0)) << 1) | int'(m_wmode));
    end
  endtask

  task automatic compare_outputs();
    check("valid",    out_if.outValid, q.size() != 0);
    check("data",     out_if.outData,  (q.size() != 0) ? (q[0] >> 1) : 0);
    check("mode",     out_if.outMode,  (q.size() != 0) ? (q[0] & 1) : 0);
    check("overflow", overflow,        m_ovf);
    check("busy",     busy,            m_cnt != 0);
`ifdef PARITY_CHECK_EN
    check("parityErr", parityErr,      m_perr);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic send_bit(input logic b);
    bitIn = b; bitValid = 1'b1;
    tick();
    bitIn = 1'b0; bitValid = 1'b0;
  endtask

  // Sends w MSB first; mode is md for bit indices below chg and inverted afterwards.
  task automatic send_word(input logic [7:0] w, input logic md, input int chg);
    for (int i = 0; i < 8; i++) begin
      mode = (i < chg) ? md : ~md;
      send_bit(w[7 - i]);
    end
`ifdef PARITY_CHECK_EN
    send_bit(^w);
`endif
    mode = 1'b0;
  endtask

  initial begin
    reset = 1'b1; active = 0; mode = 0; bitIn = 0; bitValid = 0; out_if.outReady = 1'b0;
    model_reset();
    #3;
    check("rst_valid", out_if.outValid, 0);
    check("rst_data",  out_if.outData,  0);
    check("rst_busy",  busy,            0);
    check("rst_ovf",   overflow,        0);
    #9 reset = 1'b0;

    // Locked: strobed bits must be ignored.
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    check("t1_valid", out_if.outValid, 0);
    check("t1_busy",  busy,            0);

    // Plain word.
    active = 1'b1;
    tick();
    send_word(8'hCA, 1'b0, 8);
    check("t2_valid", out_if.outValid, 1);
    check("t2_data",  out_if.outData,  8'hCA);
    check("t2_mode",  out_if.outMode,  0);
    out_if.outReady = 1'b1;
    tick();
    check("t2_empty", out_if.outValid, 0);

    // Scrambled word; the mid-word mode change must not matter.
    out_if.outReady = 1'b0;
    send_word(8'hCA, 1'b1, 3);
    check("t3_data", out_if.outData, 8'h6F);
    check("t3_mode", out_if.outMode, 1);
    out_if.outReady = 1'b1;
    tick();
    out_if.outReady = 1'b0;

    // Overflow on the fifth word, then ordered drain.
    for (int w = 1; w <= 5; w++) begin
      send_word(8'(w), 1'b0, 8);
      if (w == 5) check("t4_ovf", overflow, 1);
      else        check("t4_no_ovf", overflow, 0);
    end
    tick();
    check("t4_ovf_clear", overflow, 0);
    out_if.outReady = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      check("t4_drain", out_if.outData, w);
      tick();
    end
    check("t4_drained", out_if.outValid, 0);

    // Partial word abandoned when active drops.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("t5_busy_mid", busy, 1);
    active = 1'b0;
    tick();
    check("t5_busy_drop", busy, 0);
    active = 1'b1;
    tick();
    send_word(8'h3C, 1'b0, 8);
    check("t5_data", out_if.outData, 8'h3C);
    tick();
    check("t5_single", out_if.outValid, 0);

    // Asynchronous reset with buffered words and a partial word.
    out_if.outReady = 1'b0;
    send_word(8'h11, 1'b0, 8);
    send_word(8'h22, 1'b1, 8);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("t6_valid", out_if.outValid, 0);
    check("t6_busy",  busy,            0);
    check("t6_data",  out_if.outData,  0);
    #1 reset = 1'b0;
    tick();
    send_word(8'h5A, 1'b0, 8);
    check("t6_data_after", out_if.outData, 8'h5A);
    out_if.outReady = 1'b1;
    tick();
    check("t6_only", out_if.outValid, 0);

`ifdef PARITY_CHECK_EN
    // Bad then good parity bit on 8'hCA.
    for (int i = 0; i < 8; i++) send_bit(1'((8'hCA >> (7 - i)) & 1));
    send_bit(1'b1);
    check("t7_perr",   parityErr,       1);
    check("t7_nodata", out_if.outValid, 0);
    out_if.outReady = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'((8'hCA >> (7 - i)) & 1));
    send_bit(1'b0);
    check("t7_noerr", parityErr,      0);
    check("t7_data",  out_if.outData, 8'hCA);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      active          = ($urandom_range(0, 24) != 0);
      mode            = 1'($urandom_range(0, 1));
      bitIn           = 1'($urandom_range(0, 1));
      bitValid        = ($urandom_range(0, 3) != 0);
      out_if.outReady = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_gated_deserializer.md
Name: key_gated_deserializer

Overview:
- Sits directly downstream of the serial key-detection stage.
- Consumes that stage's active/mode outputs, plus the same serial bit line and the same qualifier strobe.
- Once active, assembles serial bits into DATA_W-bit words, optionally XOR-scrambles them per mode, and buffers them in a small FIFO with a valid/ready output handshake toward the command consumer.

Parameters:
- DATA_W, 8, word width in bits; range 2..32.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, range 2..16.
- KEY, 8'hA5, XOR mask of width DATA_W, applied to words captured in mode 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- active  in  1  unlock flag from key-detection stage; 0 = block idle.
- mode  in  1  transform select from key-detection stage; 0 = plain, 1 = XOR with KEY.
- bitIn  in  1  serial data bit, MSB first.
- bitValid  in  1  qualifies bitIn for one cycle; same strobe as the upstream validCmd.
- outData  out  DATA_W  FIFO head word.
- outMode  out  1  mode captured for the head word.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts head when outValid & outReady.
- overflow  out  1  one-cycle pulse when a completed word is dropped.
- busy  out  1  high while a word is partially assembled (bitCnt != 0).

Behaviour:
- Reset (async, immediate):
  - FIFO empty; state IDLE; bitCnt = 0; shift register cleared.
  - outData = 0, outMode = 0, outValid = 0, overflow = 0, busy = 0.
- FSM states:
  - IDLE: wait for active = 1. Enters SHIFT the cycle after active is sampled high. Bits are ignored while in IDLE.
  - SHIFT: each cycle with bitValid = 1, shreg <= {shreg[DATA_W-2:0], bitIn} and bitCnt increments.
  - Mode capture: on the first bit of a word (bitCnt = 0), mode is latched into wordMode. Mode changes mid-word do not affect that word.
  - Word completion: on the bit that makes bitCnt reach DATA_W:
    - word = {shreg[DATA_W-2:0], bitIn}, XORed with KEY if wordMode = 1.
    - {word, wordMode} is pushed to the FIFO and bitCnt returns to 0.
    - The FSM stays in SHIFT (streaming words back to back).
  - active = 0 while in SHIFT:
    - Partial word discarded; bitCnt = 0; state IDLE; no push.
    - A bit strobed in that same cycle is ignored.
- FIFO:
  - Standard circular buffer with wrap-around read/write pointers and a count.
  - outValid = (count != 0); outData/outMode are driven from the head entry.
  - Pop occurs when outValid & outReady.
  - Push latency: the word appears on outData/outValid the cycle after its last bit is sampled.
  - Push while full with no pop in the same cycle: word dropped, overflow = 1 for exactly that cycle, FIFO unchanged.
  - Push while full with a pop in the same cycle: both occur, count unchanged, no overflow.
  - Pop while empty: ignored.
- The FIFO is not flushed when active falls; already-buffered words still drain.
- busy = (bitCnt != 0).

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined:
  - After the DATA_W data bits, one additional even-parity bit is expected. The FSM enters a PARITY state for that one bitValid.
  - Parity computed over the raw (pre-XOR) bits. The word is pushed only if the parity is correct.
  - On mismatch, the word is dropped and an extra output port parityErr pulses high for 1 cycle; the FSM returns to SHIFT with bitCnt = 0.
  - An overflow drop still reports only overflow.
  - Push latency becomes one cycle after the parity bit.
- When undefined: no PARITY state, no parityErr port; words are DATA_W bits exactly.

Test Plan (DATA_W = 8, KEY = 8'hA5, FIFO_DEPTH = 4 unless stated):
- active = 0, 16 strobed bits of any value -> outValid stays 0, busy stays 0.
- active = 1, mode = 0, bits 1,1,0,0,1,0,1,0 -> cycle after 8th bit: outValid = 1, outData = 8'hCA, outMode = 0; outReady = 1 pops it, outValid = 0.
- active = 1, mode = 1 at first bit (toggled to 0 at bit 4), same bits -> outData = 8'h6F, outMode = 1.
- outReady = 0, five words 8'h01..8'h05 -> overflow pulses once on the 5th word's last bit. Then outReady = 1 drains 01,02,03,04 in order; outValid = 0 afterwards.
- 3 bits sent, active drops for 1 cycle, active rises, bits of 8'h3C sent -> only 8'h3C emitted; busy returns 0 when active falls.
- FIFO holding 2 words plus a partial word, reset asserted mid-cycle -> outValid = 0 and busy = 0 immediately; the next full word after release is the only output.
- (PARITY_CHECK_EN) 8'hCA followed by parity bit 1 -> parityErr pulse, no output; with parity bit 0 -> 8'hCA emitted.
